// File: rtl/forney_pkg.sv
// Shared types and constants for the Forney-stage dispatcher and its output register.
// Beats carry {error locator X^-1, omega(X^-1)} in GF(2^10).
package forney_pkg;

  localparam int unsigned GF_W      = 10;
  localparam int unsigned DATA_W    = 2 * GF_W;
  localparam int unsigned REQ_NB    = 4;
  localparam int unsigned MAX_BEATS = 15;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StBurst,
    StDrain
  } forney_state_e;

  typedef struct packed {
    logic [GF_W-1:0] loc;
    logic [GF_W-1:0] omega;
    logic            last;
  } forney_beat_t;

  function automatic logic onehot4(input logic [REQ_NB-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  function automatic logic [1:0] enc4(input logic [REQ_NB-1:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/forney_out_reg.sv
// Single-entry valid/ready register with pass-through refill: a new beat may be
// loaded in the same cycle the held beat is taken downstream.
module forney_out_reg
  import forney_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  forney_beat_t in_beat_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output forney_beat_t out_beat_o
);

  logic         valid_q, valid_d;
  forney_beat_t beat_q, beat_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_beat_o  = beat_q;

  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      beat_d  = in_beat_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: rtl/forney_arb_mux.sv
// Grant-consuming dispatcher: requests the arbiter, locks onto a one-hot grant and
// streams that lane's error-list burst into the shared Forney evaluator.
module forney_arb_mux
  import forney_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [REQ_NB-1:0]        s_valid,
  output logic [REQ_NB-1:0]        s_ready,
  input  logic [REQ_NB*DATA_W-1:0] s_data,
  input  logic [REQ_NB-1:0]        s_last,
  output logic                     arb_en,
  output logic [REQ_NB-1:0]        arb_req,
  input  logic [REQ_NB-1:0]        arb_grant,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic [1:0]               m_src,
  output logic                     ovf_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_BEATS);

  forney_state_e    state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [DATA_W-1:0] lane_data;
  logic              lane_valid;
  logic              lane_last;
  logic              in_valid;
  logic              in_ready;
  logic              accept;
  logic              trunc;
  forney_beat_t      in_beat;
  forney_beat_t      out_beat;

  assign lane_data  = s_data[sel_q*DATA_W +: DATA_W];
  assign lane_valid = s_valid[sel_q];
  assign lane_last  = s_last[sel_q];
  assign in_valid   = (state_q == StBurst) && lane_valid;
  assign accept     = in_valid && in_ready;
  // Final allowed beat without s_last: close the burst here, the rest comes in a later grant.
  assign trunc      = (cnt_q == CntLast) && !lane_last;

  always_comb begin
    in_beat.loc   = lane_data[DATA_W-1:GF_W];
    in_beat.omega = lane_data[GF_W-1:0];
    in_beat.last  = lane_last || trunc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|s_valid) state_d = StArb;
      end
      StArb: begin
        if (onehot4(arb_grant)) begin
          sel_d   = enc4(arb_grant);
          cnt_d   = '0;
          state_d = StBurst;
        end else begin
          state_d = StIdle;
        end
      end
      StBurst: begin
        if (accept) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (lane_last) begin
            state_d = StDrain;
          end else if (trunc) begin
            ovf_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!m_valid || m_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arb_en  = 1'b0;
    arb_req = '0;
    s_ready = '0;
    case (state_q)
      StIdle: begin
        arb_req = s_valid;
        arb_en  = |s_valid;
      end
      StBurst: s_ready[sel_q] = in_ready;
      default: ;
    endcase
  end

  forney_out_reg u_out_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_beat_i   (in_beat),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready),
    .out_beat_o  (out_beat)
  );

  assign m_data = {out_beat.loc, out_beat.omega};
  assign m_last = out_beat.last;
  assign m_src  = sel_q;
  assign ovf_o  = ovf_q;

endmodule

// File: doc/forney_arb_mux.md
# forney_arb_mux

Grant-consuming dispatcher for the Forney stage. It collects error-location beats from up to four Chien-search lanes and drives their request vector into the priority round-robin arbiter. It latches the one-hot grant the arbiter returns and streams the winning lane's burst, one codeword's error list, through a registered output to the single shared Forney evaluator. The lock is held until that burst ends.

## Interface
- REQ_NB, 4, number of requesting lanes; fixed at 4 to match the arbiter.
- DATA_W, 20, beat payload width: {error locator X^-1 [19:10], omega(X^-1) [9:0]} in GF(2^10).
- MAX_BEATS, 15, maximum beats per burst (t = 15 for RS(544,514)).
- Clocking and reset (decided): one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_valid  in  REQ_NB  per-lane beat valid.
- s_ready  out  REQ_NB  per-lane beat accept; at most one bit high.
- s_data  in  REQ_NB*DATA_W  lane k payload at [k*DATA_W +: DATA_W].
- s_last  in  REQ_NB  per-lane final beat of burst.
- arb_en  out  1  arbiter enable.
- arb_req  out  REQ_NB  arbiter request vector.
- arb_grant  in  REQ_NB  arbiter grant, registered inside the arbiter.
- m_valid  out  1  output beat valid.
- m_ready  in  1  Forney evaluator accept.
- m_data  out  DATA_W  output payload.
- m_last  out  1  final beat of burst.
- m_src  out  2  lane index of current burst.
- ovf_o  out  1  one-cycle pulse: burst truncated at MAX_BEATS.

## Operation
- FSM states: IDLE, ARB, BURST, DRAIN.
- IDLE:
  - arb_req = s_valid; arb_en = |s_valid.
  - If |s_valid, go to ARB.
  - arb_en and arb_req are 0 in every other state.
- ARB: sample arb_grant.
  - Exactly one bit set: latch its index into sel, clear beat_cnt, go to BURST.
  - Zero, or more than one bit set: return to IDLE and re-request. No beat is moved.
- BURST:
  - s_ready[sel] = ~m_valid | m_ready (single-entry output register with pass-through refill); all other s_ready bits are 0.
  - On s_valid[sel] & s_ready[sel]: load m_data/m_last from lane sel, set m_valid, increment beat_cnt.
  - Beat accepted with s_last[sel]: go to DRAIN.
  - Beat accepted with beat_cnt == MAX_BEATS-1 and s_last low: force m_last = 1, pulse ovf_o, go to DRAIN. The lane's remaining beats are taken in later grants as a fresh burst.
- DRAIN:
  - All s_ready are 0.
  - Wait until m_valid is 0, or m_valid & m_ready. Then go to IDLE.
- m_src = sel, held stable from entry to BURST until the last beat leaves the output register.
- m_valid is cleared on m_ready when no refill occurs in the same cycle.
- beat_cnt is 4 bits wide and saturates at MAX_BEATS.

## Timing
- Reset values:
  - state = IDLE.
  - s_ready, arb_en, arb_req, m_valid, m_last, ovf_o, m_data, m_src = 0.
  - sel = 0, beat_cnt = 0.
- Reset asserted mid-burst: the output register is discarded at the next edge with no partial m_last. Lanes must re-present the beat.
- First-beat latency: s_valid rises in cycle N (IDLE) → arb_en at N → ARB at N+1 → BURST at N+2 with s_ready high → m_valid at N+3.
- Throughput: one beat per cycle in BURST while m_ready is held high.
- Burst turnaround: last beat accepted in cycle M → earliest next s_ready at M+4 (DRAIN, IDLE, ARB, BURST).
- m_ready low: m_data, m_last and m_valid hold; s_ready[sel] drops in the same cycle (combinational).
- s_valid of non-selected lanes is ignored until IDLE, so there is no preemption mid-burst.
- A single-beat burst (s_last on the first beat) is legal. Sequence: BURST for 1 cycle, then DRAIN.

## Structure
- Shared package forney_pkg:
  - FSM state enum.
  - DATA_W, the GF(2^10) field width constant, and MAX_BEATS.
  - Beat struct {loc, omega, last}.
- One natural sub-module: forney_out_reg. It is the single-entry valid/ready output register and is reusable for the evaluator's own output.
- The top level holds the FSM, the grant one-hot check and the index encode, the input mux and beat_cnt.

## Test plan
- Lane 2 only: 3 beats, loc 0x001/0x055/0x3FF, last on the third, m_ready=1 → arb_req=0100; m_valid at N+3; m_src=2; three beats in order; m_last on 0x3FF.
- Lanes 0 and 3 simultaneous, equal arbiter priority, 2 beats each → lane 0's burst (m_src=0) completes fully before lane 3 (m_src=3). There are no interleaved beats.
- Lane 1 burst of 4 beats with m_ready=0 for cycles 2–5 of BURST → m_data held constant; s_ready[1]=0 while stalled; no lost or duplicated beats.
- Lane 0 presents 17 beats with no s_last → 15 beats out; m_last on beat 15; ovf_o pulses once. After re-arbitration, beats 16–17 go out as a new burst.
- Arbiter model returns grant 0110, then 0000 → the FSM returns to IDLE twice with no beat moved. A clean grant of 0010 then proceeds normally.
- rst_i high during beat 2 of a 4-beat burst → next cycle all outputs are 0 and state is IDLE. A re-presented burst completes correctly.
